tx_serializer_10b: RTL

- Transmit-side stage directly downstream of the 8b/10b encoder.
- Accepts 10-bit code groups together with the running disparity (RD) after each group.
- Shifts each group out one bit per clk, MSB (bit a) first.
- Owns the link running disparity and drives it back to the encoder's disparity input; inserts K28.5 idle groups of the correct polarity on enable, during sync and on underrun.

---
 rtl/tx_pcs_pkg.sv | 17 +
 rtl/tx_shift10.sv | 44 ++++
 rtl/tx_serializer_10b.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/tx_pcs_pkg.sv
// Shared transmit-PCS definitions: code-group width, K28.5 comma groups, link state.
package tx_pcs_pkg;

    localparam int unsigned CODE_W = 10;
    localparam int unsigned CNT_W  = 4;

    // K28.5 in abcdei fghj order; the RD- group carries six ones, the RD+ group four
    localparam logic [CODE_W-1:0] K28_5_RDN = 10'b0011111010;
    localparam logic [CODE_W-1:0] K28_5_RDP = 10'b1100000101;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } tx_state_e;

endpackage

// File: rtl/tx_shift10.sv
// 10-bit parallel-load shift register with group bit counter; MSB leaves first.
module tx_shift10
    import tx_pcs_pkg::*;
(
    input  logic              clk,
    input  logic              nreset,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [CODE_W-1:0] word_i,
    output logic              ser_o,
    output logic              frame_start_o,
    output logic              last_bit_o
);

    logic [CODE_W-1:0] shift_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic              frame_start_q;

    // Load a new group, shift one bit per clock, or hold cleared while the link is off
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            frame_start_q <= 1'b0;
        end else if (clear_i) begin
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            frame_start_q <= 1'b0;
        end else if (load_i) begin
            shift_q       <= word_i;
            bit_cnt_q     <= '0;
            frame_start_q <= 1'b1;
        end else begin
            shift_q       <= {shift_q[CODE_W-2:0], 1'b0};
            bit_cnt_q     <= bit_cnt_q + CNT_W'(1);
            frame_start_q <= 1'b0;
        end
    end

    assign ser_o         = shift_q[CODE_W-1];
    assign frame_start_o = frame_start_q;
    assign last_bit_o    = (bit_cnt_q == CNT_W'(CODE_W - 1));

endmodule

// File: rtl/tx_serializer_10b.sv
// 8b/10b transmit serializer: hold register, link running disparity and K28.5 idle insertion.
module tx_serializer_10b
    import tx_pcs_pkg::*;
#(
    parameter int unsigned       SYNC_IDLES = 4,
    parameter logic [CODE_W-1:0] K285_RDN   = K28_5_RDN,
    parameter logic [CODE_W-1:0] K285_RDP   = K28_5_RDP
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              tx_en,
    input  logic [CODE_W-1:0] word_in,
    input  logic              word_rd_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              disp_out,
    output logic              ser_out,
    output logic              frame_start,
    output logic              underrun,
    output logic              in_sync
);

    tx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic [CODE_W-1:0] hold_q, hold_d;
    logic              hold_rd_q, hold_rd_d;
    logic              hold_full_q, hold_full_d;
    logic              cur_rd_q, cur_rd_d;
    logic              word_ready_q, word_ready_d;
    logic              disp_q, disp_d;
    logic              underrun_q, underrun_d;
    logic              in_sync_q, in_sync_d;

    logic              last_bit;
    logic              boundary_c;
    logic              take_hold_c;
    logic              accept_c;
    logic [CNT_W-1:0]  idle_inc_c;
    logic [CODE_W-1:0] load_word_c;

    // Group boundary, load source and handshake decode
    always_comb begin
        boundary_c  = tx_en & ((state_q == ST_OFF) | last_bit);
        take_hold_c = boundary_c & (state_q == ST_RUN) & hold_full_q;
        accept_c    = tx_en & word_valid & word_ready_q;
        idle_inc_c  = idle_cnt_q + CNT_W'(1);
        load_word_c = take_hold_c ? hold_q : (cur_rd_q ? K285_RDP : K285_RDN);
    end

    // Next-state: link FSM, hold register, running disparity and registered outputs
    always_comb begin
        state_d     = state_q;
        idle_cnt_d  = idle_cnt_q;
        hold_d      = hold_q;
        hold_rd_d   = hold_rd_q;
        hold_full_d = hold_full_q;
        cur_rd_d    = cur_rd_q;
        underrun_d  = 1'b0;

        if (!tx_en) begin
            // drop the link: truncate the group, flush the hold, keep the disparity
            state_d     = ST_OFF;
            idle_cnt_d  = '0;
            hold_full_d = 1'b0;
        end else begin
            if (boundary_c) begin
                if (take_hold_c) begin
                    cur_rd_d    = hold_rd_q;
                    hold_full_d = 1'b0;
                end else begin
                    // K28.5 flips disparity; only a RUN idle counts as an underrun
                    cur_rd_d   = ~cur_rd_q;
                    underrun_d = (state_q == ST_RUN);
                end

                case (state_q)
                    ST_OFF: begin
                        idle_cnt_d = CNT_W'(1);
                        state_d    = (SYNC_IDLES == 1) ? ST_RUN : ST_SYNC;
                    end
                    ST_SYNC: begin
                        idle_cnt_d = idle_inc_c;
                        if (idle_inc_c == CNT_W'(SYNC_IDLES)) begin
                            state_d = ST_RUN;
                        end
                    end
                    default: begin
                    end
                endcase
            end

            // an accept on a boundary fills the hold after the boundary has used it
            if (accept_c) begin
                hold_d      = word_in;
                hold_rd_d   = word_rd_in;
                hold_full_d = 1'b1;
            end
        end

        word_ready_d = ~hold_full_d & (state_d == ST_RUN);
        disp_d       = hold_full_d ? hold_rd_d : cur_rd_d;
        in_sync_d    = (state_d == ST_RUN);
    end

    // State and output registers
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q      <= ST_OFF;
            idle_cnt_q   <= '0;
            hold_q       <= '0;
            hold_rd_q    <= 1'b0;
            hold_full_q  <= 1'b0;
            cur_rd_q     <= 1'b0;
            word_ready_q <= 1'b0;
            disp_q       <= 1'b0;
            underrun_q   <= 1'b0;
            in_sync_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idle_cnt_q   <= idle_cnt_d;
            hold_q       <= hold_d;
            hold_rd_q    <= hold_rd_d;
            hold_full_q  <= hold_full_d;
            cur_rd_q     <= cur_rd_d;
            word_ready_q <= word_ready_d;
            disp_q       <= disp_d;
            underrun_q   <= underrun_d;
            in_sync_q    <= in_sync_d;
        end
    end

    tx_shift10 u_shift (
        .clk           (clk),
        .nreset        (nreset),
        .clear_i       (~tx_en),
        .load_i        (boundary_c),
        .word_i        (load_word_c),
        .ser_o         (ser_out),
        .frame_start_o (frame_start),
        .last_bit_o    (last_bit)
    );

    assign word_ready = word_ready_q;
    assign disp_out   = disp_q;
    assign underrun   = underrun_q;
    assign in_sync    = in_sync_q;

endmodule
